// File: rtl/exec_commit_pkg.sv
// Shared constants for the commit stage: destination-type codes, FSM state encoding
// and the width of the memory timeout counter.
package exec_commit_pkg;

    localparam int DST_TYPE_WIDTH = 3;
    localparam int TMO_CNT_W      = 8;

    localparam logic [DST_TYPE_WIDTH-1:0] DST_NONE  = 3'd0;
    localparam logic [DST_TYPE_WIDTH-1:0] DST_RT    = 3'd1;
    localparam logic [DST_TYPE_WIDTH-1:0] DST_RD    = 3'd2;
    localparam logic [DST_TYPE_WIDTH-1:0] DST_PC    = 3'd3;
    localparam logic [DST_TYPE_WIDTH-1:0] DST_MEM_L = 3'd4;
    localparam logic [DST_TYPE_WIDTH-1:0] DST_MEM_S = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LATCH = 3'd1,
        S_WB    = 3'd2,
        S_BR    = 3'd3,
        S_MEM   = 3'd4,
        S_LDWB  = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    function automatic logic is_mem(input logic [DST_TYPE_WIDTH-1:0] dst);
        return (dst == DST_MEM_L) || (dst == DST_MEM_S);
    endfunction

endpackage

// File: rtl/exec_commit_mem_port.sv
// Memory req/ack port for the commit stage: holds the request and its payload until
// acknowledged, and aborts after MEM_TIMEOUT unacknowledged cycles.
module commit_mem_port
    import exec_commit_pkg::*;
#(
    parameter int DW          = 32,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          clear_i,
    input  logic          start_i,
    input  logic          we_i,
    input  logic [DW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          mem_ack_i,
    output logic          mem_req_o,
    output logic          mem_we_o,
    output logic [DW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    output logic          ack_o,
    output logic          timeout_o
);

    localparam logic [TMO_CNT_W-1:0] CNT_LAST = TMO_CNT_W'(MEM_TIMEOUT - 1);

    logic                 req_q;
    logic                 we_q;
    logic [DW-1:0]        addr_q;
    logic [DW-1:0]        wdata_q;
    logic [TMO_CNT_W-1:0] cnt_q;

    // Acks are only meaningful while a request is outstanding; stray acks are dropped.
    always_comb begin
        ack_o     = req_q & mem_ack_i;
        timeout_o = req_q & ~mem_ack_i & (cnt_q == CNT_LAST);
    end

    always_ff @(posedge clk) begin
        if (clear_i) begin
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
        end else if (start_i) begin
            req_q   <= 1'b1;
            we_q    <= we_i;
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
            cnt_q   <= '0;
        end else if (ack_o || timeout_o) begin
            req_q <= 1'b0;
            cnt_q <= '0;
        end else if (req_q) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign mem_req_o   = req_q;
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;

endmodule

// File: rtl/exec_commit.sv
// Commit stage after I-type execute: register writeback, branch redirect or word
// load/store, then holds finished until the controller drops en.
module exec_commit
    import exec_commit_pkg::*;
#(
    parameter int DW          = 32,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [DST_TYPE_WIDTH-1:0] dst_type,
    input  logic [DW-1:0]             res,
    input  logic [DW-1:0]             rt_data,
    input  logic [4:0]                rt_idx,
    input  logic [4:0]                rd_idx,
    input  logic [DW-1:0]             pc_plus4,
    input  logic [15:0]               imm16,
    output logic                      reg_we,
    output logic [4:0]                reg_waddr,
    output logic [DW-1:0]             reg_wdata,
    output logic                      pc_we,
    output logic [DW-1:0]             pc_next,
    output logic                      mem_req,
    output logic                      mem_we,
    output logic [DW-1:0]             mem_addr,
    output logic [DW-1:0]             mem_wdata,
    input  logic                      mem_ack,
    input  logic [DW-1:0]             mem_rdata,
    output logic                      err,
    output logic                      finished,
    output logic [2:0]                dbg_state
);

    state_t                    state_q;
    logic [DST_TYPE_WIDTH-1:0] dst_q;
    logic [DW-1:0]             res_q;
    logic [DW-1:0]             rt_data_q;
    logic [4:0]                rt_idx_q;
    logic [4:0]                rd_idx_q;
    logic [DW-1:0]             pc_plus4_q;
    logic [15:0]               imm16_q;
    logic                      reg_we_q;
    logic [4:0]                reg_waddr_q;
    logic [DW-1:0]             reg_wdata_q;
    logic                      pc_we_q;
    logic [DW-1:0]             pc_next_q;
    logic                      err_q;
    logic                      finished_q;

    logic                      clear;
    logic                      aligned;
    logic                      mem_start;
    logic                      mem_ack_hit;
    logic                      mem_timeout;
    logic [DW-1:0]             br_target;

    always_comb begin
        clear     = rst | ~en;
        aligned   = (res_q[1:0] == 2'b00);
        mem_start = (state_q == S_LATCH) && is_mem(dst_q) && aligned;
        br_target = pc_plus4_q + {{(DW-18){imm16_q[15]}}, imm16_q, 2'b00};
    end

    commit_mem_port #(
        .DW          (DW),
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_mem_port (
        .clk         (clk),
        .clear_i     (clear),
        .start_i     (mem_start),
        .we_i        (dst_q == DST_MEM_S),
        .addr_i      (res_q),
        .wdata_i     (rt_data_q),
        .mem_ack_i   (mem_ack),
        .mem_req_o   (mem_req),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .ack_o       (mem_ack_hit),
        .timeout_o   (mem_timeout)
    );

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q     <= S_IDLE;
            dst_q       <= '0;
            res_q       <= '0;
            rt_data_q   <= '0;
            rt_idx_q    <= '0;
            rd_idx_q    <= '0;
            pc_plus4_q  <= '0;
            imm16_q     <= '0;
            reg_we_q    <= 1'b0;
            reg_waddr_q <= '0;
            reg_wdata_q <= '0;
            pc_we_q     <= 1'b0;
            pc_next_q   <= '0;
            err_q       <= 1'b0;
            finished_q  <= 1'b0;
        end else begin
            reg_we_q <= 1'b0;
            pc_we_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    dst_q      <= dst_type;
                    res_q      <= res;
                    rt_data_q  <= rt_data;
                    rt_idx_q   <= rt_idx;
                    rd_idx_q   <= rd_idx;
                    pc_plus4_q <= pc_plus4;
                    imm16_q    <= imm16;
                    state_q    <= S_LATCH;
                end
                S_LATCH: begin
                    // No-op codes and misaligned accesses pass through S_BR with no strobe,
                    // so every non-memory path has the same two-cycle latency.
                    case (dst_q)
                        DST_RT, DST_RD: begin
                            reg_waddr_q <= (dst_q == DST_RT) ? rt_idx_q : rd_idx_q;
                            reg_wdata_q <= res_q;
                            reg_we_q    <= ((dst_q == DST_RT) ? rt_idx_q : rd_idx_q) != 5'd0;
                            state_q     <= S_WB;
                        end
                        DST_PC: begin
                            pc_we_q   <= res_q[0];
                            pc_next_q <= br_target;
                            state_q   <= S_BR;
                        end
                        DST_MEM_L, DST_MEM_S: begin
                            if (aligned) begin
                                state_q <= S_MEM;
                            end else begin
                                err_q   <= 1'b1;
                                state_q <= S_BR;
                            end
                        end
                        default: state_q <= S_BR;
                    endcase
                end
                S_WB, S_BR, S_LDWB: begin
                    finished_q <= 1'b1;
                    state_q    <= S_DONE;
                end
                S_MEM: begin
                    if (mem_ack_hit) begin
                        if (dst_q == DST_MEM_L) begin
                            reg_we_q    <= (rt_idx_q != 5'd0);
                            reg_waddr_q <= rt_idx_q;
                            reg_wdata_q <= mem_rdata;
                            state_q     <= S_LDWB;
                        end else begin
                            finished_q <= 1'b1;
                            state_q    <= S_DONE;
                        end
                    end else if (mem_timeout) begin
                        err_q      <= 1'b1;
                        finished_q <= 1'b1;
                        state_q    <= S_DONE;
                    end
                end
                S_DONE:  state_q <= S_DONE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign reg_we    = reg_we_q;
    assign reg_waddr = reg_waddr_q;
    assign reg_wdata = reg_wdata_q;
    assign pc_we     = pc_we_q;
    assign pc_next   = pc_next_q;
    assign err       = err_q;
    assign finished  = finished_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_exec_commit.sv
// Directed bench for exec_commit: writeback, branch, load/store, misalignment,
// timeout, abort by reset / en drop, and single-strobe behaviour.
module tb_exec_commit;
    import exec_commit_pkg::*;

    localparam int DW = 32;
    localparam int TMO = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [2:0]    dst_type;
    logic [DW-1:0] res;
    logic [DW-1:0] rt_data;
    logic [4:0]    rt_idx;
    logic [4:0]    rd_idx;
    logic [DW-1:0] pc_plus4;
    logic [15:0]   imm16;
    logic          reg_we;
    logic [4:0]    reg_waddr;
    logic [DW-1:0] reg_wdata;
    logic          pc_we;
    logic [DW-1:0] pc_next;
    logic          mem_req;
    logic          mem_we;
    logic [DW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;
    logic          err;
    logic          finished;
    logic [2:0]    dbg_state;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    exec_commit #(.DW(DW), .MEM_TIMEOUT(TMO)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .dst_type  (dst_type),
        .res       (res),
        .rt_data   (rt_data),
        .rt_idx    (rt_idx),
        .rd_idx    (rd_idx),
        .pc_plus4  (pc_plus4),
        .imm16     (imm16),
        .reg_we    (reg_we),
        .reg_waddr (reg_waddr),
        .reg_wdata (reg_wdata),
        .pc_we     (pc_we),
        .pc_next   (pc_next),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .err       (err),
        .finished  (finished),
        .dbg_state (dbg_state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drop en for one cycle, which returns the stage to IDLE.
    task automatic gap();
        en      = 1'b0;
        mem_ack = 1'b0;
        step();
    endtask

    task automatic issue(input logic [2:0] d, input logic [31:0] r, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [31:0] pc4, input logic [15:0] imm,
                         input logic [31:0] rtd);
        dst_type = d;
        res      = r;
        rt_idx   = rt;
        rd_idx   = rd;
        pc_plus4 = pc4;
        imm16    = imm;
        rt_data  = rtd;
        en       = 1'b1;
        step();
        // Scramble inputs after the latch edge; the stage must use its latched copies.
        dst_type = 3'd0;
        res      = 32'hDEAD_BEEF;
        rt_idx   = 5'd31;
        rd_idx   = 5'd30;
        pc_plus4 = 32'h0;
        imm16    = 16'h0;
        rt_data  = 32'h0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; dst_type = '0; res = '0; rt_data = '0; rt_idx = '0;
        rd_idx = '0; pc_plus4 = '0; imm16 = '0; mem_ack = 1'b0; mem_rdata = '0;
        step(); step();
        rst = 1'b0;
        step();
        chk("rst_state", 32'(dbg_state), 32'(S_IDLE));
        chk("rst_outs", {27'd0, reg_we, pc_we, mem_req, err, finished}, 32'd0);

        // DST_RT writeback
        issue(DST_RT, 32'h1234, 5'd5, 5'd9, 32'h0, 16'h0, 32'h0);
        chk("rt_latch_no_we", 32'(reg_we), 32'd0);
        step();
        chk("rt_we", 32'(reg_we), 32'd1);
        chk("rt_waddr", 32'(reg_waddr), 32'd5);
        chk("rt_wdata", reg_wdata, 32'h1234);
        chk("rt_not_fin", 32'(finished), 32'd0);
        step();
        chk("rt_we_1cyc", 32'(reg_we), 32'd0);
        chk("rt_fin", 32'(finished), 32'd1);
        step();
        chk("rt_hold_fin", {30'd0, reg_we, finished}, 32'd1);
        gap();
        chk("rt_gap_idle", 32'(dbg_state), 32'(S_IDLE));
        chk("rt_gap_fin0", 32'(finished), 32'd0);

        // DST_RD writeback
        issue(DST_RD, 32'hA5A5_0001, 5'd4, 5'd9, 32'h0, 16'h0, 32'h0);
        step();
        chk("rd_we", 32'(reg_we), 32'd1);
        chk("rd_waddr", 32'(reg_waddr), 32'd9);
        chk("rd_wdata", reg_wdata, 32'hA5A5_0001);
        gap();

        // Taken branch, negative offset
        issue(DST_PC, 32'd1, 5'd0, 5'd0, 32'h100, 16'hFFFE, 32'h0);
        step();
        chk("br_pc_we", 32'(pc_we), 32'd1);
        chk("br_pc_next", pc_next, 32'h0000_00F8);
        chk("br_no_reg_we", 32'(reg_we), 32'd0);
        step();
        chk("br_pc_we_1cyc", 32'(pc_we), 32'd0);
        chk("br_fin", 32'(finished), 32'd1);
        gap();

        // Not-taken branch
        issue(DST_PC, 32'd0, 5'd0, 5'd0, 32'h100, 16'hFFFE, 32'h0);
        step();
        chk("bnt_pc_we", 32'(pc_we), 32'd0);
        step();
        chk("bnt_fin", {30'd0, pc_we, finished}, 32'd1);
        gap();

        // Taken branch wrapping past 2^32
        issue(DST_PC, 32'd3, 5'd0, 5'd0, 32'hFFFF_FFFC, 16'h0002, 32'h0);
        step();
        chk("brw_pc_next", pc_next, 32'h0000_0004);
        chk("brw_pc_we", 32'(pc_we), 32'd1);
        gap();

        // Load, ack in the third request cycle
        issue(DST_MEM_L, 32'h40, 5'd7, 5'd0, 32'h0, 16'h0, 32'h0);
        step();
        chk("ld_req1", 32'(mem_req), 32'd1);
        chk("ld_we", 32'(mem_we), 32'd0);
        chk("ld_addr", mem_addr, 32'h40);
        step();
        chk("ld_req2", 32'(mem_req), 32'd1);
        step();
        chk("ld_req3", 32'(mem_req), 32'd1);
        chk("ld_addr_stable", mem_addr, 32'h40);
        mem_ack = 1'b1; mem_rdata = 32'hCAFE;
        step();
        mem_ack = 1'b0; mem_rdata = 32'h0;
        chk("ld_req_drop", 32'(mem_req), 32'd0);
        chk("ld_we_reg", 32'(reg_we), 32'd1);
        chk("ld_waddr", 32'(reg_waddr), 32'd7);
        chk("ld_wdata", reg_wdata, 32'hCAFE);
        chk("ld_not_fin", 32'(finished), 32'd0);
        step();
        chk("ld_fin", {29'd0, reg_we, err, finished}, 32'd1);
        gap();

        // Store acked in the first request cycle
        issue(DST_MEM_S, 32'h84, 5'd2, 5'd0, 32'h0, 16'h0, 32'h5555_AAAA);
        step();
        chk("st_req", 32'(mem_req), 32'd1);
        chk("st_we", 32'(mem_we), 32'd1);
        chk("st_wdata", mem_wdata, 32'h5555_AAAA);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        chk("st_done", {29'd0, mem_req, reg_we, finished}, 32'd1);
        gap();

        // Misaligned store
        issue(DST_MEM_S, 32'h42, 5'd2, 5'd0, 32'h0, 16'h0, 32'h1);
        step();
        chk("mis_no_req", 32'(mem_req), 32'd0);
        chk("mis_err", 32'(err), 32'd1);
        step();
        chk("mis_fin", {30'd0, err, finished}, 32'd3);
        step();
        chk("mis_err_sticky", 32'(err), 32'd1);
        gap();
        chk("mis_err_clr", 32'(err), 32'd0);

        // Store that is never acknowledged: request held TMO cycles
        issue(DST_MEM_S, 32'h80, 5'd2, 5'd0, 32'h0, 16'h0, 32'h9);
        for (int i = 1; i <= TMO; i++) begin
            step();
            chk($sformatf("tmo_req_c%0d", i), 32'(mem_req), 32'd1);
        end
        step();
        chk("tmo_req_drop", 32'(mem_req), 32'd0);
        chk("tmo_err_fin", {29'd0, reg_we, err, finished}, 32'd3);
        gap();

        // Reset mid-load, then a late ack
        issue(DST_MEM_L, 32'h10, 5'd3, 5'd0, 32'h0, 16'h0, 32'h0);
        step();
        chk("rstm_req", 32'(mem_req), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0; en = 1'b0;
        chk("rstm_req_drop", 32'(mem_req), 32'd0);
        chk("rstm_idle", 32'(dbg_state), 32'(S_IDLE));
        mem_ack = 1'b1; mem_rdata = 32'hBAD0;
        step();
        mem_ack = 1'b0;
        step();
        chk("rstm_late_ack", {30'd0, reg_we, finished}, 32'd0);

        // en dropped mid-load, then a late ack
        issue(DST_MEM_L, 32'h20, 5'd6, 5'd0, 32'h0, 16'h0, 32'h0);
        step();
        step();
        chk("enm_req", 32'(mem_req), 32'd1);
        en = 1'b0;
        step();
        chk("enm_req_drop", 32'(mem_req), 32'd0);
        chk("enm_idle", 32'(dbg_state), 32'(S_IDLE));
        mem_ack = 1'b1; mem_rdata = 32'hBAD1;
        step();
        mem_ack = 1'b0;
        step();
        chk("enm_late_ack", {30'd0, reg_we, mem_req}, 32'd0);

        // DST_RT to r0: no strobe, still finishes, no strobe while en held
        issue(DST_RT, 32'h77, 5'd0, 5'd0, 32'h0, 16'h0, 32'h0);
        step();
        chk("r0_no_we", 32'(reg_we), 32'd0);
        step();
        chk("r0_fin", 32'(finished), 32'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("r0_hold_%0d", i), {29'd0, reg_we, pc_we, finished}, 32'd1);
        end
        gap();

        // DST_NONE and an undefined code: finish with no side effect
        issue(DST_NONE, 32'h1, 5'd3, 5'd3, 32'h0, 16'h0, 32'h0);
        step();
        chk("none_c1", {28'd0, reg_we, pc_we, mem_req, finished}, 32'd0);
        step();
        chk("none_fin", {28'd0, reg_we, pc_we, mem_req, finished}, 32'd1);
        gap();
        issue(3'd7, 32'h1, 5'd3, 5'd3, 32'h0, 16'h0, 32'h0);
        step();
        step();
        chk("undef_fin", {27'd0, reg_we, pc_we, mem_req, err, finished}, 32'd1);
        gap();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
